mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/arb_watchdog.sv | 31 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_RESP  = 2'd2,
      ST_ABORT = 2'd3
   } arb_state_t;

   typedef enum logic {
      SRC_INSTR = 1'b0,
      SRC_DATA  = 1'b1
   } arb_src_t;

   localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;
   localparam logic [1:0]  OPLEN_WORD     = 2'd3;

   // On a tie the side that did not win last time is served, so neither side can starve.
   function automatic arb_src_t pick_source(input logic iReq, input logic dReq,
                                            input arb_src_t lastGrant);
      if (iReq && dReq) begin
         return (lastGrant == SRC_DATA) ? SRC_INSTR : SRC_DATA;
      end else if (iReq) begin
         return SRC_INSTR;
      end
      return SRC_DATA;
   endfunction

endpackage

// File: rtl/arb_watchdog.sv
// WAIT-state watchdog for mem_port_arbiter; only built when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module arb_watchdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic count_i,
   output logic expire_o
);

   localparam int unsigned CntW = $clog2(LIMIT + 1);

   logic [CntW-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (count_i) begin
         count_q <= count_q + 1'b1;
      end
   end

   // Fires during the LIMIT-th consecutive counted cycle.
   assign expire_o = count_i && (count_q == CntW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one backend memory port between instruction fetch and data requesters.
// Defining ARB_TIMEOUT_EN adds a WAIT watchdog that aborts with err=1 and ARB_ABORT_DATA.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_enable,
   input  logic [31:0] i_addr,
   output logic        i_valid,
   output logic [31:0] i_result,
   input  logic        d_enable,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_oplen,
   input  logic        d_we,
   input  logic [31:0] d_wdata,
   output logic        d_valid,
   output logic [31:0] d_result,
   output logic        err,
   output logic        m_enable,
   output logic [31:0] m_addr,
   output logic [1:0]  m_oplen,
   output logic        m_we,
   output logic [31:0] m_wdata,
   input  logic        m_valid,
   input  logic [31:0] m_result
);

   arb_state_t  state_q, state_d;
   arb_src_t    grant_q, grant_d;
   arb_src_t    lastGrant_q, lastGrant_d;
   logic        mEnable_q, mEnable_d;
   logic [31:0] mAddr_q, mAddr_d;
   logic [1:0]  mOplen_q, mOplen_d;
   logic        mWe_q, mWe_d;
   logic [31:0] mWdata_q, mWdata_d;
   logic [31:0] capture_q, capture_d;
   logic [31:0] iHold_q, iHold_d;
   logic [31:0] dHold_q, dHold_d;
   logic        respond;

`ifdef ARB_TIMEOUT_EN
   logic wdExpire;

   arb_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear_i (state_q == ST_IDLE),
      .count_i (state_q == ST_WAIT),
      .expire_o(wdExpire)
   );
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      mEnable_d   = mEnable_q;
      mAddr_d     = mAddr_q;
      mOplen_d    = mOplen_q;
      mWe_d       = mWe_q;
      mWdata_d    = mWdata_q;
      capture_d   = capture_q;
      iHold_d     = iHold_q;
      dHold_d     = dHold_q;
      case (state_q)
         ST_IDLE: begin
            if (i_enable || d_enable) begin
               grant_d     = pick_source(i_enable, d_enable, lastGrant_q);
               lastGrant_d = grant_d;
               mEnable_d   = 1'b1;
               state_d     = ST_WAIT;
               if (grant_d == SRC_INSTR) begin
                  mAddr_d  = i_addr;
                  mOplen_d = OPLEN_WORD;
                  mWe_d    = 1'b0;
                  mWdata_d = '0;
               end else begin
                  mAddr_d  = d_addr;
                  mOplen_d = d_oplen;
                  mWe_d    = d_we;
                  mWdata_d = d_wdata;
               end
            end
         end
         ST_WAIT: begin
            if (m_valid) begin
               capture_d = m_result;
               mEnable_d = 1'b0;
               state_d   = ST_RESP;
`ifdef ARB_TIMEOUT_EN
            end else if (wdExpire) begin
               capture_d = ARB_ABORT_DATA;
               mEnable_d = 1'b0;
               state_d   = ST_ABORT;
`endif
            end
         end
         ST_RESP, ST_ABORT: begin
            if (grant_q == SRC_INSTR) begin
               iHold_d = capture_q;
            end else begin
               dHold_d = capture_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset also kills any in-flight backend request immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= SRC_DATA;
         lastGrant_q <= SRC_DATA;
         mEnable_q   <= 1'b0;
         mAddr_q     <= '0;
         mOplen_q    <= '0;
         mWe_q       <= 1'b0;
         mWdata_q    <= '0;
         capture_q   <= '0;
         iHold_q     <= '0;
         dHold_q     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         mEnable_q   <= mEnable_d;
         mAddr_q     <= mAddr_d;
         mOplen_q    <= mOplen_d;
         mWe_q       <= mWe_d;
         mWdata_q    <= mWdata_d;
         capture_q   <= capture_d;
         iHold_q     <= iHold_d;
         dHold_q     <= dHold_d;
      end
   end

   assign respond  = (state_q == ST_RESP) || (state_q == ST_ABORT);
   assign i_valid  = respond && (grant_q == SRC_INSTR);
   assign d_valid  = respond && (grant_q == SRC_DATA);
   assign i_result = i_valid ? capture_q : iHold_q;
   assign d_result = d_valid ? capture_q : dHold_q;
`ifdef ARB_TIMEOUT_EN
   assign err      = (state_q == ST_ABORT);
`else
   assign err      = 1'b0;
`endif

   assign m_enable = mEnable_q;
   assign m_addr   = mAddr_q;
   assign m_oplen  = mOplen_q;
   assign m_we     = mWe_q;
   assign m_wdata  = mWdata_q;

endmodule
